phase_timer: RTL

PHASE_TIMER -- requirements
Module: phase_timer

---
 rtl/traffic_pkg.sv | 17 +
 rtl/phase_timer_if.sv | 32 +++
 rtl/tick_prescaler.sv | 40 ++++
 rtl/phase_timer.sv | 92 +++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared timer state encoding and light phase durations
package traffic_pkg;

   localparam int TLEN_W = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_DONE  = 2'd2
   } timer_state_e;

   // Phase lengths in seconds, shared with the light controller
   localparam logic [TLEN_W-1:0] RED_SECS    = 5'd20;
   localparam logic [TLEN_W-1:0] YELLOW_SECS = 5'd3;
   localparam logic [TLEN_W-1:0] GREEN_SECS  = 5'd15;

endpackage

// File: rtl/phase_timer_if.sv
// rtl/phase_timer_if.sv - phase timer control/status bundle
// t_pause exists only when PHASE_TIMER_PAUSE_EN is defined.
interface phase_timer_if;
   import traffic_pkg::*;

   logic              t_start;
   logic [TLEN_W-1:0] t_length;
`ifdef PHASE_TIMER_PAUSE_EN
   logic              t_pause;
`endif
   logic              t_flicker;
   logic              t_done;
   logic [TLEN_W-1:0] t_remaining;
   logic              busy;

   modport master (
`ifdef PHASE_TIMER_PAUSE_EN
      output t_pause,
`endif
      output t_start, t_length,
      input  t_flicker, t_done, t_remaining, busy
   );

   modport slave (
`ifdef PHASE_TIMER_PAUSE_EN
      input  t_pause,
`endif
      input  t_start, t_length,
      output t_flicker, t_done, t_remaining, busy
   );

endinterface

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - one-second prescaler, single-cycle tick on counter wrap
module tick_prescaler #(
   parameter int TICKS_PER_SEC = 100,
   parameter int CNT_W         = $clog2(TICKS_PER_SEC)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             run,
   output logic             tick,
   output logic [CNT_W-1:0] tick_cnt
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // clear wins over run; with neither asserted the count holds (pause)
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (run) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick     = run && !clear && (cnt_q == LAST);
   assign tick_cnt = cnt_q;

endmodule

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - seconds countdown timer with end-of-count flicker
// Optional pause input enabled by PHASE_TIMER_PAUSE_EN.
module phase_timer
   import traffic_pkg::*;
#(
   parameter int                TICKS_PER_SEC = 100,
   parameter logic [TLEN_W-1:0] FLICKER_SECS  = 5'd5
) (
   input  logic         clk,
   input  logic         reset,
   phase_timer_if.slave tif
);

   localparam int               CNT_W = $clog2(TICKS_PER_SEC);
   localparam logic [CNT_W-1:0] HALF  = CNT_W'(TICKS_PER_SEC / 2);

   timer_state_e      state_q, state_d;
   logic [TLEN_W-1:0] sec_q, sec_d;
   logic              done_q, done_d;

   logic             pause;
   logic             run;
   logic             clear;
   logic             tick;
   logic [CNT_W-1:0] tick_cnt;

`ifdef PHASE_TIMER_PAUSE_EN
   assign pause = tif.t_pause;
`else
   assign pause = 1'b0;
`endif

   assign run   = (state_q == ST_COUNT) && !pause;
   assign clear = tif.t_start || (state_q != ST_COUNT);

   tick_prescaler #(
      .TICKS_PER_SEC (TICKS_PER_SEC),
      .CNT_W         (CNT_W)
   ) u_prescaler (
      .clk      (clk),
      .reset    (reset),
      .clear    (clear),
      .run      (run),
      .tick     (tick),
      .tick_cnt (tick_cnt)
   );

   // A restart overrides everything, including an expiry in the same cycle
   always_comb begin
      state_d = state_q;
      sec_d   = sec_q;
      done_d  = done_q;
      if (tif.t_start) begin
         if (tif.t_length == '0) begin
            state_d = ST_DONE;
            sec_d   = '0;
            done_d  = 1'b1;
         end else begin
            state_d = ST_COUNT;
            sec_d   = tif.t_length;
            done_d  = 1'b0;
         end
      end else if (state_q == ST_COUNT && tick) begin
         if (sec_q <= 5'd1) begin
            state_d = ST_DONE;
            sec_d   = '0;
            done_d  = 1'b1;
         end else begin
            sec_d = sec_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         sec_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sec_q   <= sec_d;
         done_q  <= done_d;
      end
   end

   assign tif.busy        = (state_q == ST_COUNT);
   assign tif.t_done      = done_q;
   assign tif.t_remaining = sec_q;
   assign tif.t_flicker   = (state_q == ST_COUNT) && (sec_q <= FLICKER_SECS)
                            && (tick_cnt < HALF);

endmodule
